audio_rate_fifo: RTL

Output stage between the sound-toy core and the framework audio pins. Accepts signed 16-bit PCM samples from the core over a valid/ready handshake and buffers them in a small FIFO. Releases them at a fixed output sample rate derived from the 50 MHz system clock, and applies a coarse volume attenuation plus a click-free mute/soft-start gain ramp. Its output drives AUDIO_L/AUDIO_R directly.

---
 rtl/audio_rate_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/audio_rate_fifo.sv
// rtl/audio_rate_fifo.sv - sample FIFO released at a fixed output rate with volume shift and gain ramp
module audio_rate_fifo #(
    parameter int DEPTH = 8,
    parameter int DIV   = 1042
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    output logic                     in_ready,
    input  logic [2:0]               vol,
    input  logic                     mute,
    output logic [15:0]              audio_out,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0]        div_cnt;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [15:0]          mem [DEPTH];
    logic signed [15:0]   cur_sample;
    logic [4:0]           gain;

    logic                 tick;
    logic                 push;
    logic                 pop;
    logic signed [15:0]   next_sample;
    logic [4:0]           next_gain;
    logic signed [15:0]   shifted;
    logic signed [19:0]   shifted_ext;
    logic signed [19:0]   gain_ext;
    logic signed [19:0]   product;

    assign tick     = (div_cnt == CW'(DIV - 1));
    assign in_ready = (level < (AW + 1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = tick && (level != '0);

    // The output stage works on the post-tick sample and gain so audio_out
    // lands exactly one cycle after the tick.
    always_comb begin
        next_sample = cur_sample;
        next_gain   = gain;
        if (pop) begin
            next_sample = mem[rd_ptr];
        end
        if (tick) begin
            if (mute && (gain != 5'd0)) begin
                next_gain = gain - 5'd1;
            end else if (!mute && (gain < 5'd16)) begin
                next_gain = gain + 5'd1;
            end
        end
    end

    assign shifted     = next_sample >>> vol;
    assign shifted_ext = 20'(shifted);
    assign gain_ext    = {15'd0, next_gain};
    assign product     = shifted_ext * gain_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sample  <= '0;
            gain        <= '0;
            audio_out   <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= tick;
            underrun    <= tick && (level == '0);
            if (tick) begin
                cur_sample <= next_sample;
                gain       <= next_gain;
                audio_out  <= 16'(product >>> 4);
            end
        end
    end

endmodule
